univ_reg: RTL and testbench

Parametrised universal register: the multi-mode, N-bit successor of the single-bit enable flip-flop. Each clock edge it holds, parallel-loads, shifts, rotates, increments or decrements its contents under a 3-bit mode, gated by an enable. A synchronous clear and a cascade terminal-count output let several instances chain into wider shift registers or counters on the 74-series board netlist.

---
 rtl/univ_reg.sv | 80 ++++++++
 tb/tb_univ_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_reg
// Brief    : N-bit universal register that can hold, load, shift, rotate,
//            increment or decrement its value. It also provides a
//            terminal-count output for building cascaded counters.
// Revision : 1.0 - initial release
// ============================================================================
module univ_reg #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_r_i,
    input  logic             ser_l_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_r_o,
    output logic             ser_l_o,
    output logic             tc_o
);

    localparam logic [2:0] c_hold = 3'b000;
    localparam logic [2:0] c_load = 3'b001;
    localparam logic [2:0] c_shr  = 3'b010;
    localparam logic [2:0] c_shl  = 3'b011;
    localparam logic [2:0] c_inc  = 3'b100;
    localparam logic [2:0] c_dec  = 3'b101;
    localparam logic [2:0] c_rotr = 3'b110;
    localparam logic [2:0] c_rotl = 3'b111;

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_all_ones;
    logic             w_zero;

    always_comb begin
        w_next = r_q;
        case (mode_i)
            c_hold:  w_next = r_q;
            c_load:  w_next = d_i;
            c_shr:   w_next = {ser_r_i, r_q[WIDTH-1:1]};
            c_shl:   w_next = {r_q[WIDTH-2:0], ser_l_i};
            c_inc:   w_next = r_q + c_one;
            c_dec:   w_next = r_q - c_one;
            c_rotr:  w_next = {r_q[0], r_q[WIDTH-1:1]};
            c_rotl:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            default: w_next = r_q;
        endcase
    end

    // Clear outranks enable, so a disabled stage can still be zeroed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= RESET_VALUE;
        end else if (clr_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= w_next;
        end
    end

    assign w_all_ones = &r_q;
    assign w_zero     = ~|r_q;

    assign q_o     = r_q;
    assign ser_r_o = r_q[0];
    assign ser_l_o = r_q[WIDTH-1];
    // Terminal count is combinational so a chained stage can advance on the same edge.
    assign tc_o    = en_i & ~clr_i &
                     (((mode_i == c_inc) & w_all_ones) | ((mode_i == c_dec) & w_zero));

endmodule
`default_nettype wire

// File: tb/tb_univ_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_reg
// Brief    : Self-checking bench for univ_reg (8-bit main instance plus a
//            two-stage 4-bit cascade).
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, en, sr, sl;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       ser_r_o, ser_l_o, tc;

    // cascade stimulus
    logic       cas_ld, lo_en;
    logic [2:0] cas_mode;
    logic [3:0] lo_d, hi_d, lo_q, hi_q;
    logic       lo_tc, hi_tc, hi_en;
    logic       lo_sr, lo_sl, hi_sr, hi_sl;

    int n_tests = 0;
    int n_fail  = 0;
    int model_q;

    always #5 clk = ~clk;

    univ_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en), .mode_i(mode),
        .d_i(d), .ser_r_i(sr), .ser_l_i(sl), .q_o(q),
        .ser_r_o(ser_r_o), .ser_l_o(ser_l_o), .tc_o(tc)
    );

    assign hi_en = cas_ld | lo_tc;

    univ_reg #(.WIDTH(4), .RESET_VALUE(4'h0)) u_lo (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0), .en_i(lo_en), .mode_i(cas_mode),
        .d_i(lo_d), .ser_r_i(1'b0), .ser_l_i(1'b0), .q_o(lo_q),
        .ser_r_o(lo_sr), .ser_l_o(lo_sl), .tc_o(lo_tc)
    );

    univ_reg #(.WIDTH(4), .RESET_VALUE(4'h0)) u_hi (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0), .en_i(hi_en), .mode_i(cas_mode),
        .d_i(hi_d), .ser_r_i(1'b0), .ser_l_i(1'b0), .q_o(hi_q),
        .ser_r_o(hi_sr), .ser_l_o(hi_sl), .tc_o(hi_tc)
    );

    typedef struct {
        logic       clr;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sr;
        logic       sl;
        logic [7:0] exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic e, logic [2:0] m, logic [7:0] dd,
                                logic r, logic l, logic [7:0] eq, logic et);
        vec_t v;
        v.clr = c; v.en = e; v.mode = m; v.d = dd; v.sr = r; v.sl = l;
        v.exp_q = eq; v.exp_tc = et;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour expressed arithmetically on an 8-bit value.
    function automatic int ref_next(int cq, logic c, logic e, logic [2:0] m,
                                    logic [7:0] dd, logic r, logic l);
        if (c) return 0;
        if (!e) return cq;
        case (m)
            3'd1: return int'(dd);
            3'd2: return (r ? 128 : 0) + cq / 2;
            3'd3: return (cq * 2 + (l ? 1 : 0)) % 256;
            3'd4: return (cq + 1) % 256;
            3'd5: return (cq + 255) % 256;
            3'd6: return (cq % 2) * 128 + cq / 2;
            3'd7: return (cq * 2) % 256 + cq / 128;
            default: return cq;
        endcase
    endfunction

    function automatic logic ref_tc(int cq, logic c, logic e, logic [2:0] m);
        return e && !c && ((m == 3'd4 && cq == 255) || (m == 3'd5 && cq == 0));
    endfunction

    task automatic drive(input logic c, input logic e, input logic [2:0] m,
                         input logic [7:0] dd, input logic r, input logic l);
        clr = c; en = e; mode = m; d = dd; sr = r; sl = l;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        cas_ld = 1'b0; lo_en = 1'b0; cas_mode = 3'd0; lo_d = 4'h0; hi_d = 4'h0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("reset_q", q, 8'hA5);
        chk("reset_ser_r", ser_r_o, 1'b1);
        chk("reset_ser_l", ser_l_o, 1'b1);
        chk("reset_tc", tc, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("hold_after_reset", q, 8'hA5);

        // Directed vector table, applied in order from q=A5
        tbl.push_back(mk(0, 1, 3'd1, 8'h3C, 0, 0, 8'h3C, 0));
        tbl.push_back(mk(0, 0, 3'd1, 8'hFF, 0, 0, 8'h3C, 0));
        tbl.push_back(mk(1, 1, 3'd4, 8'hFF, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'd1, 8'h81, 1, 1, 8'h81, 0));
        tbl.push_back(mk(0, 1, 3'd2, 8'hFF, 0, 1, 8'h40, 0));
        tbl.push_back(mk(0, 1, 3'd2, 8'hFF, 0, 1, 8'h20, 0));
        tbl.push_back(mk(0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0));
        tbl.push_back(mk(0, 1, 3'd3, 8'h00, 0, 1, 8'h03, 0));
        tbl.push_back(mk(0, 1, 3'd3, 8'h00, 0, 1, 8'h07, 0));
        tbl.push_back(mk(0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0));
        tbl.push_back(mk(0, 1, 3'd6, 8'h00, 0, 0, 8'hC0, 0));
        tbl.push_back(mk(0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0));
        tbl.push_back(mk(0, 1, 3'd7, 8'h00, 0, 0, 8'h03, 0));
        tbl.push_back(mk(0, 1, 3'd1, 8'h5A, 0, 0, 8'h5A, 0));
        tbl.push_back(mk(0, 1, 3'd4, 8'h00, 1, 1, 8'h5B, 0));
        tbl.push_back(mk(0, 1, 3'd1, 8'hFE, 0, 0, 8'hFE, 0));
        tbl.push_back(mk(0, 1, 3'd4, 8'h00, 0, 0, 8'hFF, 1));
        tbl.push_back(mk(0, 1, 3'd4, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'd0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 8'hFF, 0));
        tbl.push_back(mk(1, 0, 3'd5, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 3'd5, 8'h00, 0, 0, 8'h00, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sr, tbl[i].sl);
            tick();
            chk($sformatf("vec%0d_q", i), q, tbl[i].exp_q);
            chk($sformatf("vec%0d_tc", i), tc, tbl[i].exp_tc);
        end

        // dec from zero: terminal count asserted before the wrapping edge
        drive(0, 1, 3'd5, 8'h00, 0, 0);
        #1 chk("dec_zero_tc", tc, 1'b1);
        tick();
        chk("dec_wrap_q", q, 8'hFF);
        chk("dec_wrap_ser_r", ser_r_o, 1'b1);

        // Two 4-bit stages chained through tc
        cas_ld = 1'b1; cas_mode = 3'd1; lo_en = 1'b1; lo_d = 4'hF; hi_d = 4'h0;
        tick();
        cas_ld = 1'b0; cas_mode = 3'd4;
        #1 chk("cas_lo_tc", lo_tc, 1'b1);
        tick();
        chk("cas_0f_inc", {hi_q, lo_q}, 8'h10);
        cas_ld = 1'b1; cas_mode = 3'd1; lo_d = 4'hF; hi_d = 4'hF;
        tick();
        cas_ld = 1'b0; cas_mode = 3'd4;
        tick();
        chk("cas_ff_inc", {hi_q, lo_q}, 8'h00);
        lo_en = 1'b0;

        // Asynchronous reset in the middle of counting
        drive(0, 1, 3'd1, 8'h7F, 0, 0);
        tick();
        drive(0, 1, 3'd4, 8'h00, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk("midcount_reset_q", q, 8'hA5);
        @(posedge clk);
        #1 chk("reset_edge_hold", q, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_inc_after_reset", q, 8'hA6);

        // Randomized run against the reference model
        model_q = 8'hA6;
        for (int k = 0; k < 400; k++) begin
            logic       rc, re, rr, rl;
            logic [2:0] rm;
            logic [7:0] rd;
            rc = ($urandom_range(0, 15) == 0);
            re = ($urandom_range(0, 7) != 0);
            rm = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rd = 8'hFF;
                1: rd = 8'h00;
                default: rd = 8'($urandom);
            endcase
            rr = 1'($urandom);
            rl = 1'($urandom);
            drive(rc, re, rm, rd, rr, rl);
            #1 chk("rand_tc", tc, ref_tc(model_q, rc, re, rm));
            model_q = ref_next(model_q, rc, re, rm, rd, rr, rl);
            tick();
            chk("rand_q", q, model_q);
            chk("rand_ser_r", ser_r_o, model_q % 2);
            chk("rand_ser_l", ser_l_o, model_q / 128);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
